// File: rtl/adv_dma_write_controller.sv
// ============================================================================
// adv_dma_write_controller
// ----------------------------------------------------------------------------
// Device-to-host DMA write engine. A configured transfer is split into chunks
// that respect the PCIe max payload size and never cross a 4 KB boundary on
// either the host or the device side. For each chunk the engine:
//   1. reads the data from device memory with one AXI4 INCR burst (AR/R),
//   2. buffers the beats in a 128-bit first-word-fall-through FIFO,
//   3. issues one memory-write request to the TLP engine, which drains the
//      FIFO and pulses dma_write_done once the payload is gone.
// When the whole transfer finishes (or aborts on an AXI read error) the
// engine raises int_valid and waits for int_done.
//
// Ports
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   pcie_dcommand             PCIe Device Control; [7:5] = max payload size
//   dma_write_host_address    host byte address     ([3:0] ignored)
//   dma_write_device_address  device byte address   ([3:0] ignored)
//   dma_write_length          transfer bytes        ([3:0] ignored)
//   dma_write_start           1-cycle start pulse, dropped while busy
//   dma_write_busy            high from accepted start until int_done
//   dma_write_error           sticky per transfer, set on rresp != OKAY
//   ar* / r*                  AXI4 read master (128-bit data)
//   dma_write_addr/len/valid  per-chunk request to the TLP engine (len in DW)
//   dma_write_done            TLP sent and payload consumed
//   dma_write_data/_empty/_rd FIFO head, empty flag, pop strobe
//   int_valid / int_done      completion interrupt handshake
// ============================================================================
module adv_dma_write_controller #(
    parameter int P_MAX_PAYLOAD = 256,  // power of 2, 128..4096
    parameter int P_FIFO_DEPTH  = 32    // >= P_MAX_PAYLOAD/16
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [15:0]  pcie_dcommand,
    input  logic [31:0]  dma_write_host_address,
    input  logic [31:0]  dma_write_device_address,
    input  logic [31:0]  dma_write_length,
    input  logic         dma_write_start,
    output logic         dma_write_busy,
    output logic         dma_write_error,
    output logic [31:0]  araddr,
    output logic [7:0]   arlen,
    output logic [2:0]   arsize,
    output logic [1:0]   arburst,
    output logic [3:0]   arcache,
    output logic [2:0]   arprot,
    output logic         arvalid,
    input  logic         arready,
    input  logic [127:0] rdata,
    input  logic [1:0]   rresp,
    input  logic         rlast,
    input  logic         rvalid,
    output logic         rready,
    output logic [31:0]  dma_write_addr,
    output logic [9:0]   dma_write_len,
    output logic         dma_write_valid,
    input  logic         dma_write_done,
    output logic [127:0] dma_write_data,
    output logic         dma_write_data_empty,
    input  logic         dma_write_data_rd,
    output logic         int_valid,
    input  logic         int_done
);

    localparam int CNT_W = $clog2(P_FIFO_DEPTH + 1);
    localparam int PTR_W = (P_FIFO_DEPTH > 1) ? $clog2(P_FIFO_DEPTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CALC,
        S_AR,
        S_RDATA,
        S_TLP,
        S_INT
    } state_t;

    state_t state, state_nxt;

    // Transfer context; all addresses/lengths are kept 16-byte aligned.
    logic [31:0] host_q;
    logic [31:0] dev_q;
    logic [31:0] remain_q;
    logic [12:0] chunk_q;     // current chunk in bytes (up to 4096)
    logic        error_q;

    // FIFO state
    logic [127:0]     fifo_mem [P_FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] fifo_cnt;
    logic             fifo_push, fifo_pop, fifo_flush, fifo_fits;

    // ------------------------------------------------------------------
    // Chunk size: min(remaining, MPS, room to host 4K page, room to dev 4K page)
    // ------------------------------------------------------------------
    logic [2:0]  mps_code;
    logic [12:0] mps_bytes, host_room, dev_room, chunk_calc;

    // NOTE: every signal driven here gets a value before any condition, so no latch is inferred.
    always_comb begin
        mps_code  = (pcie_dcommand[7:5] > 3'd5) ? 3'd5 : pcie_dcommand[7:5];
        mps_bytes = 13'd128 << mps_code;
        if (mps_bytes > 13'(P_MAX_PAYLOAD)) begin
            mps_bytes = 13'(P_MAX_PAYLOAD);
        end
        host_room  = 13'd4096 - {1'b0, host_q[11:0]};
        dev_room   = 13'd4096 - {1'b0, dev_q[11:0]};
        chunk_calc = mps_bytes;
        if (host_room < chunk_calc) chunk_calc = host_room;
        if (dev_room < chunk_calc)  chunk_calc = dev_room;
        if (remain_q < {19'd0, chunk_calc}) chunk_calc = remain_q[12:0];
    end

    // The whole burst must fit before AR is issued, so R can never stall on a full FIFO.
    assign fifo_fits = (32'(P_FIFO_DEPTH) - 32'(fifo_cnt)) >= {23'd0, chunk_calc[12:4]};

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (dma_write_start) begin
                    state_nxt = (dma_write_length[31:4] == '0) ? S_INT : S_CALC;
                end
            end
            S_CALC:  if (fifo_fits) state_nxt = S_AR;
            S_AR:    if (arready)   state_nxt = S_RDATA;
            S_RDATA: begin
                if (rvalid && rlast) begin
                    state_nxt = (error_q || (rresp != 2'b00)) ? S_INT : S_TLP;
                end
            end
            S_TLP: begin
                if (dma_write_done) begin
                    state_nxt = (remain_q == {19'd0, chunk_q}) ? S_INT : S_CALC;
                end
            end
            S_INT:   if (int_done) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        dma_write_busy  = 1'b1;
        arvalid         = 1'b0;
        rready          = 1'b0;
        dma_write_valid = 1'b0;
        int_valid       = 1'b0;
        case (state)
            S_IDLE:  dma_write_busy  = 1'b0;
            S_AR:    arvalid         = 1'b1;
            S_RDATA: rready          = 1'b1;
            S_TLP:   dma_write_valid = 1'b1;
            S_INT:   int_valid       = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Transfer context
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            host_q   <= '0;
            dev_q    <= '0;
            remain_q <= '0;
            chunk_q  <= '0;
            error_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (dma_write_start) begin
                        host_q   <= {dma_write_host_address[31:4], 4'h0};
                        dev_q    <= {dma_write_device_address[31:4], 4'h0};
                        remain_q <= {dma_write_length[31:4], 4'h0};
                        error_q  <= 1'b0;
                    end
                end
                S_CALC: chunk_q <= chunk_calc;
                S_RDATA: begin
                    if (rvalid && (rresp != 2'b00)) error_q <= 1'b1;
                end
                S_TLP: begin
                    if (dma_write_done) begin
                        host_q   <= host_q + {19'd0, chunk_q};
                        dev_q    <= dev_q + {19'd0, chunk_q};
                        remain_q <= remain_q - {19'd0, chunk_q};
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Data FIFO (first-word-fall-through)
    // ------------------------------------------------------------------
    assign fifo_push  = (state == S_RDATA) && rvalid;
    assign fifo_pop   = dma_write_data_rd && (fifo_cnt != '0);
    // RDATA -> INT only happens on an error abort; stale payload is discarded.
    assign fifo_flush = (state == S_RDATA) && (state_nxt == S_INT);

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(P_FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else if (fifo_flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (fifo_push) wr_ptr <= ptr_inc(wr_ptr);
            if (fifo_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({fifo_push, fifo_pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: ;
            endcase
        end
    end

    // NOTE: storage has no reset; entry validity is defined solely by the pointers and count.
    always_ff @(posedge i_clk) begin
        if (fifo_push) fifo_mem[wr_ptr] <= rdata;
    end

    // ------------------------------------------------------------------
    // Output assignments
    // ------------------------------------------------------------------
    assign dma_write_error      = error_q;
    assign araddr               = dev_q;
    // A 4096-byte chunk has [11:4] == 0, and 0 - 1 yields the required 255.
    assign arlen                = chunk_q[11:4] - 8'd1;
    assign arsize               = 3'b100;
    assign arburst              = 2'b01;
    assign arcache              = 4'b0011;
    assign arprot               = 3'b000;
    assign dma_write_addr       = host_q;
    // 1024 DW wraps to 0, which is the PCIe encoding of a 4 KB payload.
    assign dma_write_len        = chunk_q[11:2];
    assign dma_write_data       = fifo_mem[rd_ptr];
    assign dma_write_data_empty = (fifo_cnt == '0);

    // Ignored input bits, collected so they are visibly consumed.
    logic unused_bits;
    assign unused_bits = ^{pcie_dcommand[15:8], pcie_dcommand[4:0],
                           dma_write_host_address[3:0], dma_write_device_address[3:0],
                           dma_write_length[3:0]};

endmodule

// File: tb/tb_adv_dma_write_controller.sv
// ============================================================================
// tb_adv_dma_write_controller
// ----------------------------------------------------------------------------
// Cycle-driven bench: one task plays AXI slave, TLP engine and interrupt
// controller at every falling edge. Expected chunk lists come from a plain
// arithmetic model of the chunking rules; data payloads are a function of
// the device address so every popped word can be checked.
// ============================================================================
module tb_adv_dma_write_controller;

    localparam int P_MAX_PAYLOAD = 256;
    localparam int P_FIFO_DEPTH  = 32;
    localparam int BUDGET        = 5000;

    logic         i_clk = 1'b0;
    logic         i_rst_n = 1'b0;
    logic [15:0]  pcie_dcommand = '0;
    logic [31:0]  dma_write_host_address = '0;
    logic [31:0]  dma_write_device_address = '0;
    logic [31:0]  dma_write_length = '0;
    logic         dma_write_start = 1'b0;
    logic         dma_write_busy, dma_write_error;
    logic [31:0]  araddr;
    logic [7:0]   arlen;
    logic [2:0]   arsize;
    logic [1:0]   arburst;
    logic [3:0]   arcache;
    logic [2:0]   arprot;
    logic         arvalid;
    logic         arready = 1'b0;
    logic [127:0] rdata = '0;
    logic [1:0]   rresp = '0;
    logic         rlast = 1'b0;
    logic         rvalid = 1'b0;
    logic         rready;
    logic [31:0]  dma_write_addr;
    logic [9:0]   dma_write_len;
    logic         dma_write_valid;
    logic         dma_write_done = 1'b0;
    logic [127:0] dma_write_data;
    logic         dma_write_data_empty;
    logic         dma_write_data_rd = 1'b0;
    logic         int_valid;
    logic         int_done = 1'b0;

    always #5 i_clk = ~i_clk;

    adv_dma_write_controller #(
        .P_MAX_PAYLOAD(P_MAX_PAYLOAD),
        .P_FIFO_DEPTH (P_FIFO_DEPTH)
    ) dut (
        .i_clk                   (i_clk),
        .i_rst_n                 (i_rst_n),
        .pcie_dcommand           (pcie_dcommand),
        .dma_write_host_address  (dma_write_host_address),
        .dma_write_device_address(dma_write_device_address),
        .dma_write_length        (dma_write_length),
        .dma_write_start         (dma_write_start),
        .dma_write_busy          (dma_write_busy),
        .dma_write_error         (dma_write_error),
        .araddr                  (araddr),
        .arlen                   (arlen),
        .arsize                  (arsize),
        .arburst                 (arburst),
        .arcache                 (arcache),
        .arprot                  (arprot),
        .arvalid                 (arvalid),
        .arready                 (arready),
        .rdata                   (rdata),
        .rresp                   (rresp),
        .rlast                   (rlast),
        .rvalid                  (rvalid),
        .rready                  (rready),
        .dma_write_addr          (dma_write_addr),
        .dma_write_len           (dma_write_len),
        .dma_write_valid         (dma_write_valid),
        .dma_write_done          (dma_write_done),
        .dma_write_data          (dma_write_data),
        .dma_write_data_empty    (dma_write_data_empty),
        .dma_write_data_rd       (dma_write_data_rd),
        .int_valid               (int_valid),
        .int_done                (int_done)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Responder behaviour for the next run_xfer call
    int cfg_ar_stall, cfg_done_delay, cfg_int_delay, cfg_err_c, cfg_err_b, cfg_mid_start;
    bit cfg_gaps, cfg_abort;

    // Observations of the last run_xfer call
    int          res_n_ar, res_n_tlp, res_arlen0, res_tlp_len0;
    logic [31:0] res_last_addr;
    logic        res_err;

    typedef struct {
        logic [31:0] host, dev, len;
        logic [2:0]  code;
        int          err_c, err_b;
        int          n_ar, n_tlp, arlen0, tlp_len0;
        logic [31:0] last_addr;
        bit          err;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] pattern(input logic [31:0] a);
        return {a ^ 32'hA5A5_5A5A, ~a, a + 32'h1234_5678, {a[15:0], a[31:16]}};
    endfunction

    task automatic idle_inputs();
        dma_write_start   = 1'b0;
        arready           = 1'b0;
        rvalid            = 1'b0;
        rlast             = 1'b0;
        rresp             = 2'b00;
        rdata             = '0;
        dma_write_done    = 1'b0;
        dma_write_data_rd = 1'b0;
        int_done          = 1'b0;
    endtask

    task automatic set_defaults();
        cfg_ar_stall   = 0;
        cfg_done_delay = 0;
        cfg_int_delay  = 1;
        cfg_err_c      = 0;
        cfg_err_b      = 0;
        cfg_mid_start  = -1;
        cfg_gaps       = 1'b0;
        cfg_abort      = 1'b0;
    endtask

    task automatic check_reset_outputs(input string name);
        check(name, {arvalid, rready, dma_write_valid, int_valid,
                     dma_write_busy, dma_write_error, dma_write_data_empty}, 7'b0000001);
    endtask

    // ------------------------------------------------------------------
    // One complete transfer against the reference chunk list
    // ------------------------------------------------------------------
    task automatic run_xfer(input logic [31:0] host, input logic [31:0] dev,
                            input logic [31:0] len, input logic [2:0] code);
        logic [31:0] mh[$], md[$];
        int          mb[$];
        logic [31:0] h, d, rem;
        int          c, mps, b, exp_ar, exp_tlp;
        bit          exp_err, finished, aborted;
        int          cyc, first_ar, n_ar, n_tlp, n_int, data_errs, stable_errs;
        int          ar_wait, r_left, r_idx, t_left, t_idx, t_wait, i_wait;
        bit          ar_seen, r_hold, t_seen, i_seen;
        logic [31:0] r_addr, ar_addr_q, t_addr;
        logic [7:0]  ar_len_q;
        logic [9:0]  t_len;
        logic        err_at_int;

        // Reference chunking
        h = host & ~32'hF;
        d = dev & ~32'hF;
        rem = len & ~32'hF;
        c = int'(code);
        if (c > 5) c = 5;
        mps = 128 << c;
        if (mps > P_MAX_PAYLOAD) mps = P_MAX_PAYLOAD;
        while (rem != 0) begin
            b = mps;
            if (4096 - int'(h % 4096) < b) b = 4096 - int'(h % 4096);
            if (4096 - int'(d % 4096) < b) b = 4096 - int'(d % 4096);
            if (rem < 32'(b)) b = int'(rem);
            mh.push_back(h);
            md.push_back(d);
            mb.push_back(b);
            h += 32'(b);
            d += 32'(b);
            rem -= 32'(b);
        end
        exp_ar  = mb.size();
        exp_tlp = mb.size();
        exp_err = 1'b0;
        if (cfg_err_c > 0 && cfg_err_c <= mb.size()) begin
            exp_ar  = cfg_err_c;
            exp_tlp = cfg_err_c - 1;
            exp_err = 1'b1;
        end

        finished = 0; aborted = 0; first_ar = -1;
        n_ar = 0; n_tlp = 0; n_int = 0; data_errs = 0; stable_errs = 0;
        ar_wait = 0; r_left = 0; r_idx = 0; t_left = 0; t_idx = 0; t_wait = 0; i_wait = 0;
        ar_seen = 0; r_hold = 0; t_seen = 0; i_seen = 0;
        r_addr = '0; ar_addr_q = '0; ar_len_q = '0; t_addr = '0; t_len = '0; err_at_int = 1'b0;
        res_arlen0 = -1; res_tlp_len0 = -1; res_last_addr = '0;

        @(negedge i_clk);
        dma_write_host_address   = host;
        dma_write_device_address = dev;
        dma_write_length         = len;
        pcie_dcommand            = {8'h00, code, 5'h00};
        dma_write_start          = 1'b1;
        @(negedge i_clk);
        cyc = 1;

        while (!finished && cyc < BUDGET) begin
            idle_inputs();
            if (cyc == 1) check("busy_after_start", dma_write_busy, 1'b1);
            if (cyc == cfg_mid_start) begin
                dma_write_host_address = 32'hDEAD_0000;
                dma_write_length       = 32'h10;
                dma_write_start        = 1'b1;
            end
            if (cfg_abort && rready && r_idx >= 2) begin
                i_rst_n = 1'b0;
                aborted = 1;
                break;
            end

            // AXI read data
            if (r_left > 0 && (r_hold || !cfg_gaps || ($urandom_range(0, 2) != 0))) begin
                rvalid = 1'b1;
                rdata  = pattern(r_addr + 32'(16 * r_idx));
                rlast  = (r_left == 1);
                rresp  = (n_ar == cfg_err_c && r_idx + 1 == cfg_err_b) ? 2'b10 : 2'b00;
                if (rready) begin
                    r_idx++;
                    r_left--;
                    r_hold = 0;
                end else begin
                    r_hold = 1;
                end
            end

            // AXI read address
            if (arvalid) begin
                if (!ar_seen) begin
                    ar_seen = 1; ar_addr_q = araddr; ar_len_q = arlen; ar_wait = 0;
                    if (first_ar < 0) first_ar = cyc;
                end else if (araddr != ar_addr_q || arlen != ar_len_q) begin
                    stable_errs++;
                end
                if (ar_wait >= cfg_ar_stall) begin
                    arready = 1'b1;
                    if (n_ar < mb.size())
                        check($sformatf("ar%0d", n_ar), {araddr, 8'h00, arlen},
                              {md[n_ar], 8'h00, 8'(mb[n_ar] / 16 - 1)});
                    if (n_ar == 0) res_arlen0 = int'(arlen);
                    n_ar++;
                    r_addr = araddr; r_left = int'(arlen) + 1; r_idx = 0; ar_seen = 0;
                end else begin
                    ar_wait++;
                end
            end

            // TLP engine
            if (dma_write_valid) begin
                if (!t_seen) begin
                    t_seen = 1; t_addr = dma_write_addr; t_len = dma_write_len;
                    if (n_tlp < mb.size())
                        check($sformatf("tlp%0d", n_tlp), {dma_write_addr, 6'h00, dma_write_len},
                              {mh[n_tlp], 6'h00, 10'(mb[n_tlp] / 4)});
                    if (n_tlp == 0) res_tlp_len0 = int'(dma_write_len);
                    res_last_addr = dma_write_addr;
                    n_tlp++;
                    t_left = (t_len == 10'd0) ? 256 : int'(t_len) / 4;
                    t_idx = 0; t_wait = 0;
                end else if (dma_write_addr != t_addr || dma_write_len != t_len) begin
                    stable_errs++;
                end
                if (t_left > 0) begin
                    if (!dma_write_data_empty) begin
                        dma_write_data_rd = 1'b1;
                        if (n_tlp > mb.size() ||
                            dma_write_data != pattern(md[n_tlp-1] + 32'(16 * t_idx)))
                            data_errs++;
                        t_idx++;
                        t_left--;
                    end
                end else if (t_wait >= cfg_done_delay) begin
                    dma_write_done = 1'b1;
                    t_seen = 0;
                end else begin
                    t_wait++;
                end
            end

            // Interrupt controller
            if (int_valid) begin
                if (!i_seen) begin
                    i_seen = 1; n_int++; err_at_int = dma_write_error; i_wait = 0;
                end
                if (i_wait >= cfg_int_delay) begin
                    int_done = 1'b1;
                    finished = 1;
                end else begin
                    i_wait++;
                end
            end

            @(negedge i_clk);
            cyc++;
        end

        if (aborted) return;
        idle_inputs();
        check("xfer_completed", finished, 1'b1);
        check("ar_latency", first_ar, (exp_ar > 0) ? 2 : -1);
        check("ar_count", n_ar, exp_ar);
        check("tlp_count", n_tlp, exp_tlp);
        check("payload_words", data_errs, 0);
        check("stable_while_stalled", stable_errs, 0);
        check("int_count", n_int, 1);
        check("error_at_int", err_at_int, exp_err);
        check("idle_after_int", {dma_write_busy, int_valid, dma_write_data_empty}, 3'b001);
        if (!finished) begin
            i_rst_n = 1'b0;
            @(negedge i_clk);
            i_rst_n = 1'b1;
        end
        res_n_ar  = n_ar;
        res_n_tlp = n_tlp;
        res_err   = err_at_int;
    endtask

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    initial begin
        vec_t vecs[8];
        vecs[0] = '{32'h1000, 32'h0000, 32'd256,  3'd1, 0, 0, 1, 1, 15, 64, 32'h1000, 1'b0};
        vecs[1] = '{32'h2000, 32'h0100, 32'd1024, 3'd0, 0, 0, 8, 8,  7, 32, 32'h2380, 1'b0};
        vecs[2] = '{32'h0FC0, 32'h0000, 32'd128,  3'd1, 0, 0, 2, 2,  3, 16, 32'h1000, 1'b0};
        vecs[3] = '{32'h3000, 32'h0000, 32'd256,  3'd1, 1, 3, 1, 0, 15,  0, 32'h0000, 1'b1};
        vecs[4] = '{32'h5000, 32'h0000, 32'd0,    3'd1, 0, 0, 0, 0,  0,  0, 32'h0000, 1'b0};
        vecs[5] = '{32'h4000, 32'h2000, 32'd512,  3'd7, 0, 0, 2, 2, 15, 64, 32'h4100, 1'b0};
        vecs[6] = '{32'h0000, 32'h0FF0, 32'd64,   3'd1, 0, 0, 2, 2,  0,  4, 32'h0010, 1'b0};
        vecs[7] = '{32'h100F, 32'h0005, 32'h2F,   3'd1, 0, 0, 1, 1,  1,  8, 32'h1000, 1'b0};

        set_defaults();
        idle_inputs();
        i_rst_n = 1'b0;
        repeat (3) @(negedge i_clk);
        check_reset_outputs("reset_state");
        i_rst_n = 1'b1;
        @(negedge i_clk);

        // Directed table
        foreach (vecs[i]) begin
            set_defaults();
            cfg_err_c = vecs[i].err_c;
            cfg_err_b = vecs[i].err_b;
            run_xfer(vecs[i].host, vecs[i].dev, vecs[i].len, vecs[i].code);
            check($sformatf("v%0d_n_ar", i), res_n_ar, vecs[i].n_ar);
            check($sformatf("v%0d_n_tlp", i), res_n_tlp, vecs[i].n_tlp);
            check($sformatf("v%0d_err", i), res_err, vecs[i].err);
            if (vecs[i].n_ar > 0) check($sformatf("v%0d_arlen0", i), res_arlen0, vecs[i].arlen0);
            if (vecs[i].n_tlp > 0) begin
                check($sformatf("v%0d_tlp_len0", i), res_tlp_len0, vecs[i].tlp_len0);
                check($sformatf("v%0d_last_addr", i), res_last_addr, vecs[i].last_addr);
            end
        end

        // Randomized transfers with random handshake timing
        for (int i = 0; i < 40; i++) begin
            logic [31:0] h, d, l;
            logic [2:0]  c;
            set_defaults();
            h = 32'($urandom_range(0, 3) << 12) | 32'($urandom_range(0, 255) << 4);
            d = $urandom;
            l = 32'($urandom_range(0, 64) * 16 + $urandom_range(0, 15));
            c = 3'($urandom_range(0, 7));
            cfg_ar_stall   = $urandom_range(0, 3);
            cfg_done_delay = $urandom_range(0, 3);
            cfg_int_delay  = $urandom_range(0, 3);
            cfg_gaps       = 1'b1;
            cfg_err_c      = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 2) : 0;
            cfg_err_b      = 1;
            run_xfer(h, d, l, c);
        end

        // Long stalls on arready and dma_write_done with a start pulse mid-transfer
        set_defaults();
        cfg_ar_stall   = 20;
        cfg_done_delay = 20;
        cfg_int_delay  = 5;
        cfg_mid_start  = 10;
        run_xfer(32'h1000, 32'h0, 32'd256, 3'd1);
        check("stall_n_ar", res_n_ar, 1);
        check("stall_n_tlp", res_n_tlp, 1);
        check("stall_last_addr", res_last_addr, 32'h1000);

        // Reset asserted in the middle of RDATA, after an error beat
        set_defaults();
        cfg_abort = 1'b1;
        cfg_err_c = 1;
        cfg_err_b = 1;
        run_xfer(32'h1000, 32'h0, 32'd256, 3'd1);
        #1;
        check_reset_outputs("reset_mid_rdata");
        idle_inputs();
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        check_reset_outputs("after_reset_release");

        // Recovery after the abort
        set_defaults();
        run_xfer(32'h1000, 32'h0, 32'd256, 3'd1);
        check("recover_n_tlp", res_n_tlp, 1);
        check("recover_err", res_err, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
